// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine driving a request/acknowledge data-memory port.
// Define MEM_TIMEOUT_EN to add an ack watchdog (TMO state, err plus 32'hDEADBEEF load result).
module mem_access_unit #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stage_reset_n,
  input  logic              ram_wren,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_wstrb,
  output logic [31:0]       dm_wdata,
  input  logic              dm_ack,
  input  logic [31:0]       dm_rdata,
  output logic [31:0]       load_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
`ifdef MEM_TIMEOUT_EN
  localparam logic [1:0]  ST_TMO   = 2'd3;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt_r;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT_CYCLES != 0);
`endif

  logic [1:0]  state_r;
  logic        wren_q_r;
  logic [1:0]  off_r;
  logic [2:0]  funct3_r;
  logic        srst_s;
  logic        trigger_s;
  logic        illegal_s;
  logic [3:0]  strb_s;
  logic [31:0] wdata_s;
  logic [31:0] lane_s;
  logic [31:0] ext_s;

  assign srst_s    = !reset_n || !stage_reset_n;
  assign trigger_s = ram_wren && !wren_q_r && (state_r == ST_IDLE);

  // Access legality: size/sign code, store size and natural alignment.
  always_comb begin
    illegal_s = 1'b0;
    if (mem_read && mem_write) begin
      illegal_s = 1'b1;
    end else if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) begin
      illegal_s = 1'b1;
    end else if (mem_write && funct3[2]) begin
      illegal_s = 1'b1;
    end else if (funct3[1:0] == 2'b01 && addr[0]) begin
      illegal_s = 1'b1;
    end else if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00) begin
      illegal_s = 1'b1;
    end else begin
      illegal_s = 1'b0;
    end
  end

  // Store lane strobes and replicated store data; loads never strobe.
  always_comb begin
    strb_s  = 4'b0000;
    wdata_s = 32'd0;
    case (funct3[1:0])
      2'b00: begin
        strb_s  = 4'b0001 << addr[1:0];
        wdata_s = {4{wdata[7:0]}};
      end
      2'b01: begin
        strb_s  = 4'b0011 << addr[1:0];
        wdata_s = {2{wdata[15:0]}};
      end
      2'b10: begin
        strb_s  = 4'b1111;
        wdata_s = wdata;
      end
      default: begin
        strb_s  = 4'b0000;
        wdata_s = 32'd0;
      end
    endcase
    if (!mem_write) begin
      strb_s = 4'b0000;
    end else begin
      strb_s = strb_s;
    end
  end

  // Lane select of the returned word and sign/zero extension for the latched access.
  always_comb begin
    lane_s = dm_rdata >> {off_r, 3'b000};
    case (funct3_r)
      3'b000:  ext_s = {{24{lane_s[7]}}, lane_s[7:0]};
      3'b001:  ext_s = {{16{lane_s[15]}}, lane_s[15:0]};
      3'b100:  ext_s = {24'd0, lane_s[7:0]};
      3'b101:  ext_s = {16'd0, lane_s[15:0]};
      default: ext_s = lane_s;
    endcase
  end

  // Registered copy of ram_wren, tracked through reset so an enable held across reset never retriggers.
  always_ff @(posedge clk) begin
    wren_q_r <= ram_wren;
  end

  // Access sequencer with registered memory-port and result outputs.
  always_ff @(posedge clk) begin
    if (srst_s) begin
      state_r   <= ST_IDLE;
      dm_req    <= 1'b0;
      dm_we     <= 1'b0;
      dm_addr   <= {ADDR_W{1'b0}};
      dm_wstrb  <= 4'b0000;
      dm_wdata  <= 32'd0;
      load_data <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      off_r     <= 2'b00;
      funct3_r  <= 3'b000;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt_r <= 16'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (trigger_s) begin
            err <= 1'b0;
            if (!mem_read && !mem_write) begin
              state_r <= ST_DONE;
            end else if (illegal_s) begin
              err     <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              state_r  <= ST_REQ;
              busy     <= 1'b1;
              dm_req   <= 1'b1;
              dm_we    <= mem_write;
              dm_addr  <= {addr[ADDR_W-1:2], 2'b00};
              dm_wstrb <= strb_s;
              dm_wdata <= wdata_s;
              off_r    <= addr[1:0];
              funct3_r <= funct3;
`ifdef MEM_TIMEOUT_EN
              tmo_cnt_r <= 16'd0;
`endif
            end
          end
        end
        ST_REQ: begin
          if (dm_ack) begin
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_wstrb <= 4'b0000;
            busy     <= 1'b0;
            state_r  <= ST_DONE;
            if (!dm_we) begin
              load_data <= ext_s;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (tmo_cnt_r == TMO_LAST) begin
            dm_req    <= 1'b0;
            dm_we     <= 1'b0;
            dm_wstrb  <= 4'b0000;
            busy      <= 1'b0;
            err       <= 1'b1;
            load_data <= 32'hDEAD_BEEF;
            state_r   <= ST_TMO;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 16'd1;
          end
`endif
        end
        ST_DONE: begin
          done    <= 1'b1;
          state_r <= ST_IDLE;
        end
`ifdef MEM_TIMEOUT_EN
        ST_TMO: begin
          done    <= 1'b1;
          state_r <= ST_IDLE;
        end
`endif
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Executes the MEM stage of the multicycle core.
- Consumes the stage controller's ram_wren and stage_reset_n, plus the decoded load/store controls and the EX/MEM address and data.
- Drives a simple request/acknowledge data-memory port.
- Performs byte/half/word access with strobes and load sign/zero extension. Presents load data to the MEM/WB register and a busy flag for future stall support.

Parameters:
- ADDR_W, 32, data-memory byte-address width.
- TIMEOUT_CYCLES, 255, ack watchdog limit. Used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset
- stage_reset_n  in  1  stage-controller soft reset, active-low
- ram_wren  in  1  MEM-stage enable from the stage controller
- mem_read  in  1  decoded load
- mem_write  in  1  decoded store
- funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  ADDR_W  byte address from EX/MEM
- wdata  in  32  store data from EX/MEM
- dm_req  out  1  memory request
- dm_we  out  1  memory write
- dm_addr  out  ADDR_W  word-aligned address (addr with [1:0] forced to 0)
- dm_wstrb  out  4  byte strobes
- dm_wdata  out  32  lane-aligned store data
- dm_ack  in  1  memory acknowledge, single-cycle pulse
- dm_rdata  in  32  read word, valid with dm_ack
- load_data  out  32  extended load result
- busy  out  1  access in progress
- done  out  1  one-cycle completion pulse
- err  out  1  sticky error for the current access

Behaviour:
- Reset: reset_n is synchronous, active-low; clock is clk. stage_reset_n low acts identically (synchronous).
- Values under either reset: state IDLE; dm_req=0, dm_we=0, dm_addr=0, dm_wstrb=0, dm_wdata=0; load_data=0, busy=0, done=0, err=0.
- Trigger: rising edge of ram_wren, detected with a registered copy. A held ram_wren never retriggers. A trigger while not IDLE is ignored.
- States: IDLE, REQ, DONE (plus TMO with the optional feature).
- IDLE + trigger, three cases:
  - Neither mem_read nor mem_write: go to DONE, err=0, load_data unchanged.
  - Illegal access: go to DONE with err=1 and no dm_req. Illegal means both read and write set; funct3 in {011,110,111}; store funct3 not in {000,001,010}; halfword with addr[0]=1; or word with addr[1:0]!=0.
  - Otherwise: latch operands, go to REQ, busy=1.
- REQ:
  - dm_req=1, with dm_we, dm_addr, dm_wstrb and dm_wdata held stable until dm_ack.
  - Store SB: strobe 0001<<addr[1:0], data {4{wdata[7:0]}}.
  - Store SH: strobe 0011<<addr[1:0], data {2{wdata[15:0]}}.
  - Store SW: strobe 1111, data wdata.
  - Loads: dm_wstrb=0.
  - On dm_ack: dm_req deasserts the next cycle. For a load, dm_rdata is captured, lane-selected by addr[1:0], and sign- or zero-extended per funct3 into load_data. Then go to DONE.
- Request timing: dm_req rises one cycle after the trigger edge. An ack arriving in the same cycle as dm_req rises is legal.
- DONE: done=1 for exactly one cycle, busy=0; return to IDLE.
- load_data: holds until the next completed load. err holds until the next trigger.
- Latency: a valid access with same-cycle ack completes with done at trigger+2 cycles. An illegal or no-op access completes with done at trigger+1.
- dm_ack seen in IDLE or DONE is ignored.
- Reset in REQ: dm_req drops at that edge; a late ack is ignored.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined: an 8..16-bit counter runs in REQ. If it reaches TIMEOUT_CYCLES without dm_ack, go to TMO: dm_req=0, err=1, load_data=32'hDEADBEEF, done pulses, then IDLE.
- Undefined: no counter; REQ waits indefinitely for dm_ack.

Test Plan:
- LB at addr 0x103, dm_rdata 0x80FF_1234 acked same cycle -> load_data 0xFFFF_FF80, done at trigger+2, err=0.
- LHU at addr 0x102, dm_rdata 0x8001_0000, ack after 5 cycles -> dm_req held 6 cycles, load_data 0x0000_8001.
- SB at addr 0x201, wdata 0x0000_00AB -> dm_we=1, dm_addr 0x200, dm_wstrb 0010, dm_wdata 0xABAB_ABAB.
- LW at addr 0x102 -> no dm_req, err=1, done at trigger+1. Read and write both set -> same response.
- reset_n low in REQ, then ack one cycle later -> dm_req=0 after the edge, no done, state IDLE.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> err=1, load_data 0xDEADBEEF, done after timeout. ram_wren held 3 cycles -> exactly one access.
